// File: rtl/hazard_scoreboard_pkg.sv
// Shared control types for the decode-stage hazard logic.
//   regidx_t          5-bit architectural register index
//   ctrl_reg_val_t    result class of a producer (ALU, load data, mul/div)
//   hazard_forward_t  forward select handed to the decode-stage operand muxes
//   ctrl_branch_t     branch class of the consumer sitting in D
//   scb_entry_t       one shadow entry tracking a producer through E, M, W
package hazard_scoreboard_pkg;

    typedef logic [4:0] regidx_t;

    typedef enum logic [1:0] {
        VAL_ALU_RES  = 2'd0,
        VAL_MEM_DATA = 2'd1,
        VAL_MULDIV   = 2'd2
    } ctrl_reg_val_t;

    typedef enum logic [1:0] {
        HAZ_DEFAULT   = 2'd0,
        HAZ_ALU_RES_E = 2'd1,
        HAZ_ALU_RES_M = 2'd2,
        HAZ_RES_W     = 2'd3
    } hazard_forward_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JR   = 2'd3
    } ctrl_branch_t;

    typedef struct packed {
        logic          valid;
        logic          wen;
        regidx_t       dst;
        ctrl_reg_val_t val;
    } scb_entry_t;

    localparam scb_entry_t SCB_EMPTY = '{
        valid: 1'b0,
        wen:   1'b0,
        dst:   5'd0,
        val:   VAL_ALU_RES
    };

    // r0 is hard-wired zero, so it never creates a dependency.
    function automatic logic entry_match(input scb_entry_t e, input regidx_t idx);
        return e.valid && e.wen && (e.dst == idx) && (idx != 5'd0);
    endfunction

    // Branches resolve in D and so need operands earlier than E-stage forwarding.
    function automatic logic is_branch(input ctrl_branch_t br);
        return (br == BR_BEQ) || (br == BR_BNE) || (br == BR_JR);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_port_eval.sv
// Per-read-port dependency search over the shadow entries.
//   se, sm, sw  shadow entries for the producers in E, M and W
//   busy        the producer in E is a mul/div still occupying E
//   branch      branch class of the consumer in D
//   rd_idx      source register read by this port
//   fwd_sel     forward select for this port (HAZ_DEFAULT when stalling)
//   stall       no forward path exists yet for this port
module hazard_port_eval
    import hazard_scoreboard_pkg::*;
(
    input  scb_entry_t      se,
    input  scb_entry_t      sm,
    input  scb_entry_t      sw,
    input  logic            busy,
    input  ctrl_branch_t    branch,
    input  regidx_t         rd_idx,
    output hazard_forward_t fwd_sel,
    output logic            stall
);

    logic            br_cons;
    hazard_forward_t sel_raw;

    assign br_cons = is_branch(branch);

    // Youngest producer first; only the first match decides.
    always_comb begin
        sel_raw = HAZ_DEFAULT;
        stall   = 1'b0;
        if (entry_match(se, rd_idx)) begin
            if (br_cons) begin
                case (se.val)
                    VAL_ALU_RES:  sel_raw = HAZ_ALU_RES_E;
                    VAL_MEM_DATA: stall   = 1'b1;
                    VAL_MULDIV: begin
                        if (busy) stall   = 1'b1;
                        else      sel_raw = HAZ_ALU_RES_E;
                    end
                    default:      stall   = 1'b1;
                endcase
            end else begin
                // Load-use and mul-use wait; plain ALU results use E-stage forwarding.
                case (se.val)
                    VAL_ALU_RES: sel_raw = HAZ_DEFAULT;
                    default:     stall   = 1'b1;
                endcase
            end
        end else if (entry_match(sm, rd_idx)) begin
            if (br_cons) begin
                if (sm.val == VAL_MEM_DATA) stall   = 1'b1;
                else                        sel_raw = HAZ_ALU_RES_M;
            end
        end else if (entry_match(sw, rd_idx)) begin
            sel_raw = HAZ_RES_W;
        end
    end

    assign fwd_sel = stall ? HAZ_DEFAULT : sel_raw;

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard: shadows register writes through E, M, W,
// answers decode's read ports with a forward select or a stall, and owns the
// multi-cycle mul/div occupancy counter.
//   clk, resetn        clock, synchronous active-low reset
//   issue_*            instruction in D offered to E this cycle
//   branch_d, rd_idx   consumer query from decode
//   hold_m             M cannot advance
//   flush_d            squash the instruction in D
//   fwd_sel            per-port forward select
//   stall_d            freeze F/D
//   hold_e             freeze E
//   bubble_e           E loads a bubble this cycle
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned NREAD      = 2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              issue_valid,
    input  logic                              issue_wen,
    input  regidx_t                           issue_dst,
    input  ctrl_reg_val_t                     issue_val,
    input  ctrl_branch_t                      branch_d,
    input  regidx_t         [NREAD-1:0]       rd_idx,
    input  logic                              hold_m,
    input  logic                              flush_d,
    output hazard_forward_t [NREAD-1:0]       fwd_sel,
    output logic                              stall_d,
    output logic                              hold_e,
    output logic                              bubble_e
);

    localparam int unsigned CntW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_LAT - 1);

    scb_entry_t      se_q, se_d;
    scb_entry_t      sm_q, sm_d;
    scb_entry_t      sw_q, sw_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic             busy;
    logic             issue_bubble;
    logic             muldiv_enter;
    logic [NREAD-1:0] port_stall;
    scb_entry_t       issue_entry;

    assign busy   = se_q.valid && (se_q.val == VAL_MULDIV) && (cnt_q != '0);
    assign hold_e = hold_m | busy;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        hazard_port_eval u_eval (
            .se      (se_q),
            .sm      (sm_q),
            .sw      (sw_q),
            .busy    (busy),
            .branch  (branch_d),
            .rd_idx  (rd_idx[p]),
            .fwd_sel (fwd_sel[p]),
            .stall   (port_stall[p])
        );
    end

    assign stall_d      = (|port_stall) | hold_e;
    assign issue_bubble = stall_d | flush_d | !issue_valid;
    assign bubble_e     = !hold_e & issue_bubble;
    assign muldiv_enter = !hold_e && !issue_bubble && (issue_val == VAL_MULDIV);

    always_comb begin
        issue_entry       = SCB_EMPTY;
        issue_entry.valid = 1'b1;
        issue_entry.wen   = issue_wen;
        issue_entry.dst   = issue_dst;
        issue_entry.val   = issue_val;
    end

    always_comb begin
        sw_d = hold_m ? SCB_EMPTY : sm_q;

        // A busy E with M free sends bubbles down into M.
        if (hold_m)       sm_d = sm_q;
        else if (!hold_e) sm_d = se_q;
        else              sm_d = SCB_EMPTY;

        if (hold_e)            se_d = se_q;
        else if (issue_bubble) se_d = SCB_EMPTY;
        else                   se_d = issue_entry;

        // The counter keeps running even while M holds everything upstream.
        if (muldiv_enter)       cnt_d = CntLoad;
        else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
        else                    cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            se_q  <= SCB_EMPTY;
            sm_q  <= SCB_EMPTY;
            sw_q  <= SCB_EMPTY;
            cnt_q <= '0;
        end else begin
            se_q  <= se_d;
            sm_q  <= sm_d;
            sw_q  <= sw_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NREAD = 2;

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        issue_valid;
    logic                        issue_wen;
    regidx_t                     issue_dst;
    ctrl_reg_val_t               issue_val;
    ctrl_branch_t                branch_d;
    regidx_t         [NREAD-1:0] rd_idx;
    logic                        hold_m;
    logic                        flush_d;
    hazard_forward_t [NREAD-1:0] fwd_sel;
    logic                        stall_d;
    logic                        hold_e;
    logic                        bubble_e;

    // Second instance with single-cycle mul/div: E must never be held by busy.
    hazard_forward_t [NREAD-1:0] fwd_sel1;
    logic                        stall_d1;
    logic                        hold_e1;
    logic                        bubble_e1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MULDIV_LAT(4), .NREAD(NREAD)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_dst   (issue_dst),
        .issue_val   (issue_val),
        .branch_d    (branch_d),
        .rd_idx      (rd_idx),
        .hold_m      (hold_m),
        .flush_d     (flush_d),
        .fwd_sel     (fwd_sel),
        .stall_d     (stall_d),
        .hold_e      (hold_e),
        .bubble_e    (bubble_e)
    );

    hazard_scoreboard #(.MULDIV_LAT(1), .NREAD(NREAD)) dut1 (
        .clk         (clk),
        .resetn      (resetn),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_dst   (issue_dst),
        .issue_val   (issue_val),
        .branch_d    (branch_d),
        .rd_idx      (rd_idx),
        .hold_m      (hold_m),
        .flush_d     (flush_d),
        .fwd_sel     (fwd_sel1),
        .stall_d     (stall_d1),
        .hold_e      (hold_e1),
        .bubble_e    (bubble_e1)
    );

    typedef struct {
        logic            iv;
        logic            wen;
        regidx_t         dst;
        ctrl_reg_val_t   val;
        ctrl_branch_t    br;
        regidx_t         rd0;
        regidx_t         rd1;
        logic            hm;
        logic            fl;
        logic            rst;
        hazard_forward_t f0;
        hazard_forward_t f1;
        logic            st;
        logic            he;
        logic            be;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic wen, input int dst,
                                input ctrl_reg_val_t val, input ctrl_branch_t br,
                                input int rd0, input int rd1, input logic hm, input logic fl,
                                input hazard_forward_t f0, input hazard_forward_t f1,
                                input logic st, input logic he, input logic be);
        vec_t v;
        v.iv = iv; v.wen = wen; v.dst = regidx_t'(dst); v.val = val; v.br = br;
        v.rd0 = regidx_t'(rd0); v.rd1 = regidx_t'(rd1); v.hm = hm; v.fl = fl;
        v.rst = 1'b0; v.f0 = f0; v.f1 = f1; v.st = st; v.he = he; v.be = be;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // One vector = one cycle: drive, sample at the falling edge, then clock.
    task automatic step(input int idx, input vec_t v);
        issue_valid = v.iv;
        issue_wen   = v.wen;
        issue_dst   = v.dst;
        issue_val   = v.val;
        branch_d    = v.br;
        rd_idx[0]   = v.rd0;
        rd_idx[1]   = v.rd1;
        hold_m      = v.hm;
        flush_d     = v.fl;
        @(negedge clk);
        check("fwd_sel0", idx, int'(fwd_sel[0]), int'(v.f0));
        check("fwd_sel1", idx, int'(fwd_sel[1]), int'(v.f1));
        check("stall_d",  idx, int'(stall_d),    int'(v.st));
        check("hold_e",   idx, int'(hold_e),     int'(v.he));
        check("bubble_e", idx, int'(bubble_e),   int'(v.be));
        check("hold_e_lat1", idx, int'(hold_e1), int'(v.hm));
        resetn = !v.rst;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    localparam ctrl_reg_val_t A = VAL_ALU_RES;
    localparam ctrl_reg_val_t L = VAL_MEM_DATA;
    localparam ctrl_reg_val_t X = VAL_MULDIV;
    localparam hazard_forward_t D  = HAZ_DEFAULT;
    localparam hazard_forward_t FE = HAZ_ALU_RES_E;
    localparam hazard_forward_t FM = HAZ_ALU_RES_M;
    localparam hazard_forward_t FW = HAZ_RES_W;

    vec_t tbl [33];
    vec_t hv;

    initial begin
        //            iv wen dst val br      rd0 rd1 hm fl  f0  f1  st he be
        // reset state, NOP issuing
        tbl[0]  = mk(1, 0, 0,  A, BR_NONE, 1,  2,  0, 0, D,  D,  0, 0, 0);
        // ALU r8 -> BEQ forwards from E; non-branch uses default
        tbl[1]  = mk(1, 1, 8,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[2]  = mk(1, 0, 0,  A, BR_BEQ,  8,  0,  0, 0, FE, D,  0, 0, 0);
        tbl[3]  = mk(1, 1, 8,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[4]  = mk(1, 0, 0,  A, BR_NONE, 8,  8,  0, 0, D,  D,  0, 0, 0);
        tbl[5]  = mk(0, 0, 0,  A, BR_NONE, 8,  8,  0, 0, D,  D,  0, 0, 1);
        // r8 now in W; issue load r9
        tbl[6]  = mk(1, 1, 9,  L, BR_NONE, 8,  0,  0, 0, FW, D,  0, 0, 0);
        // load-use: one stall cycle
        tbl[7]  = mk(1, 1, 11, A, BR_NONE, 9,  0,  0, 0, D,  D,  1, 0, 1);
        tbl[8]  = mk(1, 1, 11, A, BR_NONE, 9,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[9]  = mk(0, 0, 0,  A, BR_NONE, 9,  11, 0, 0, FW, D,  0, 0, 1);
        // load r9 -> BEQ: two stall cycles then W
        tbl[10] = mk(1, 1, 9,  L, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[11] = mk(1, 0, 0,  A, BR_BEQ,  9,  0,  0, 0, D,  D,  1, 0, 1);
        tbl[12] = mk(1, 0, 0,  A, BR_BEQ,  9,  0,  0, 0, D,  D,  1, 0, 1);
        tbl[13] = mk(1, 0, 0,  A, BR_BEQ,  9,  0,  0, 0, FW, D,  0, 0, 0);
        // MUL r10: E held 3 cycles, JR waits then forwards from E
        tbl[14] = mk(1, 1, 10, X, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[15] = mk(1, 0, 0,  A, BR_JR,   10, 0,  0, 0, D,  D,  1, 1, 0);
        tbl[16] = mk(1, 0, 0,  A, BR_JR,   10, 0,  0, 0, D,  D,  1, 1, 0);
        tbl[17] = mk(1, 0, 0,  A, BR_JR,   10, 0,  0, 0, D,  D,  1, 1, 0);
        tbl[18] = mk(1, 0, 0,  A, BR_JR,   10, 0,  0, 0, FE, D,  0, 0, 0);
        tbl[19] = mk(0, 0, 0,  A, BR_JR,   10, 0,  0, 0, FM, D,  0, 0, 1);
        // ALU r4, ALU r3, then hold_m for 3 cycles with BNE on r3 / r4
        tbl[20] = mk(1, 1, 4,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[21] = mk(1, 1, 3,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[22] = mk(0, 0, 0,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 1);
        tbl[23] = mk(0, 0, 0,  A, BR_BNE,  3,  4,  1, 0, FM, FW, 1, 1, 0);
        tbl[24] = mk(0, 0, 0,  A, BR_BNE,  3,  4,  1, 0, FM, D,  1, 1, 0);
        tbl[25] = mk(0, 0, 0,  A, BR_BNE,  3,  4,  1, 0, FM, D,  1, 1, 0);
        tbl[26] = mk(0, 0, 0,  A, BR_BNE,  3,  4,  0, 0, FM, D,  0, 0, 1);
        // r0 never matches; r5 in SE and SW -> SE wins
        tbl[27] = mk(1, 1, 0,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[28] = mk(1, 1, 5,  A, BR_BEQ,  0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[29] = mk(1, 1, 6,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[30] = mk(1, 1, 5,  A, BR_NONE, 0,  0,  0, 0, D,  D,  0, 0, 0);
        tbl[31] = mk(1, 0, 0,  A, BR_BEQ,  5,  6,  0, 1, FE, FM, 0, 0, 1);
        tbl[32] = mk(0, 0, 0,  A, BR_BEQ,  5,  6,  0, 0, FM, FW, 0, 0, 1);

        resetn      = 1'b0;
        issue_valid = 1'b0;
        issue_wen   = 1'b0;
        issue_dst   = '0;
        issue_val   = VAL_ALU_RES;
        branch_d    = BR_NONE;
        rd_idx      = '0;
        hold_m      = 1'b0;
        flush_d     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 33; i++) step(i, tbl[i]);

        // Reset while a mul/div occupies E: entry dropped, no hold afterwards.
        step(100, mk(1, 1, 12, X, BR_NONE, 0,  0, 0, 0, D, D, 0, 0, 0));
        hv = mk(0, 0, 0, A, BR_JR, 12, 5, 0, 0, D, D, 1, 1, 0);
        hv.rst = 1'b1;
        step(101, hv);
        step(102, mk(1, 0, 0,  A, BR_JR,   12, 0, 0, 0, D, D, 0, 0, 0));
        step(103, mk(1, 0, 0,  A, BR_NONE, 12, 0, 0, 0, D, D, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
